bcd_run_timer: RTL and testbench
================================

# bcd_run_timer

Parametrised multi-digit BCD run timer for the irrigation controller. It generalises the fixed tens-of-seconds digit counter into a chain of DIGITS BCD digits with alternating modulus (units mod 10, tens mod TENS_MOD). It supports up or down counting, preset load, pause/resume and a terminal-count pulse. It sits between the 1 Hz prescaler, which supplies `tick`, and the valve-control FSM, which consumes `done`. `value` drives the display decoders.

## Interface

- `DIGITS`, default 4: number of BCD digits; legal range 1..8.
- `TENS_MOD`, default 6: modulus of odd-indexed digits (1, 3, ...); legal range 2..10. Even-indexed digits are always mod 10.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `clear`  in  1  asynchronous, active-low reset.
- `tick`  in  1  count-enable strobe, one `clk` cycle wide.
- `start`  in  1  start/resume request, level-sampled each cycle.
- `stop`  in  1  pause/abort request, level-sampled each cycle.
- `up`  in  1  mode, sampled only at a load start: 1 = count up from 0 to preset, 0 = count down from preset to 0.
- `preset`  in  4*DIGITS  BCD duration; digit i is `preset[4i+3:4i]`.
- `value`  out  4*DIGITS  current BCD count; digit 0 is least significant.
- `running`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse on reaching the terminal value.
- `expired`  out  1  level, high while in DONE.

## Operation

- **States:** IDLE, RUN, PAUSE, DONE (2-bit register). Each cycle is evaluated in this priority order:
  - `stop`
  - `start`
  - `tick`
- **Reset:** state is IDLE; `value`, `running`, `done` and `expired` are all 0.
- **IDLE or DONE, `start`=1 and `stop`=0:**
  - This is a load start.
  - The mode register captures `up`.
  - A terminal register captures the sanitised preset.
  - `value` loads 0 if up, or the sanitised preset if down.
  - State goes to RUN.
- **Sanitising:** any preset digit above its modulus-1 is clamped to modulus-1, e.g. 9 in a mod-6 digit becomes 5.
- **Zero-length load:** if `value` already equals the terminal value at load (sanitised preset is all zero), state goes to DONE instead of RUN, and `done` pulses.
- **RUN, `stop`=1:** go to PAUSE; `value` holds.
- **RUN, `tick`=1:**
  - `value` steps by one with ripple carry/borrow across digits.
  - Count up: digit at modulus-1 wraps to 0 and carries.
  - Count down: digit at 0 wraps to modulus-1 and borrows.
  - If the new value equals the terminal (preset for up, 0 for down), state goes to DONE and `done` pulses.
- **PAUSE:**
  - `start` with `stop`=0 resumes to RUN without reload.
  - `stop` returns to IDLE with `value` unchanged.
  - `tick` is ignored.
- **DONE:**
  - `value` holds the terminal value.
  - `stop` goes to IDLE.
  - `start` performs a fresh load start.
- **IDLE:** `tick` and `stop` have no effect.
- **Simultaneous `start` and `stop`:** `stop` wins in every state.
- **Full-scale wrap:** the terminal compare prevents wrap-around within a run. The all-max value, e.g. 59:59 for DIGITS=4, is reachable and legal.

## Timing

- All outputs are registered; there are no combinational paths from inputs to outputs.
- `start` sampled at edge n gives `running`=1 and the loaded `value` after edge n.
- A `tick` high at edge n updates `value` after edge n; the first decrement needs a tick at edge n+1 or later.
- Terminal reached at edge n:
  - `done`=1 during cycle n..n+1 only.
  - `expired`=1 from edge n onward.
  - `running`=0 from edge n.
- Latency from the final tick to `done` is one edge, the same edge that updates `value`.
- A `tick` coincident with the RUN→PAUSE `stop` is dropped.
- A `tick` coincident with a load `start` is not applied; the loaded value is exact.
- Asserting `clear` mid-run forces reset values immediately, independent of `clk`. Deassertion takes effect at the next `clk` edge.

## Test plan

- **Down-count borrow chain** (DIGITS=4, TENS_MOD=6, preset 0x0102, `up`=0, start, then a tick every 4 cycles): `value` goes 0x0102 → 0x0101 → 0x0100 → 0x0059. `done` pulses exactly once, on the edge `value` becomes 0x0000. `expired`=1 afterwards.
- **Up-count to preset** (preset 0x0010, `up`=1): `value` goes 0x0000 … 0x0009 → 0x0010. `done` pulses on that edge and `value` stays 0x0010.
- **Sanitise and zero-length:**
  - Preset 0x0979 loads as 0x0959.
  - Preset 0x0000 with `up`=0 gives DONE, with `done` pulsing one edge after `start` and `running` never high.
- **Pause/resume and priority:**
  - `stop` mid-run freezes `value`; ticks in PAUSE do not change it.
  - `start` resumes from the frozen value.
  - `start`+`stop` together in RUN → PAUSE.
  - `stop` in PAUSE → IDLE with `value` held.
- **Coincident edges:**
  - A tick on the same cycle as a load start: `value` equals the preset.
  - A tick on the same cycle as `stop`: no step.
  - `start` in DONE reloads and runs again.
- **Asynchronous reset mid-run** (pulse `clear` low between clock edges with `value`=0x0037): all outputs are 0 before the next edge. After release, state is IDLE and ticks are ignored.

Source files
------------

// File: rtl/bcd_run_timer.sv
// Multi-digit BCD run timer: up/down count toward a preset with pause/resume.
// The digit moduli alternate 10 / TENS_MOD, and a terminal compare stops the count.
module bcd_run_timer #(
  parameter int DIGITS   = 4,
  parameter int TENS_MOD = 6
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                tick,
  input  logic                start,
  input  logic                stop,
  input  logic                up,
  input  logic [4*DIGITS-1:0] preset,
  output logic [4*DIGITS-1:0] value,
  output logic                running,
  output logic                done,
  output logic                expired
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t         state_reg;
  logic           mode_up_reg;
  logic [W-1:0]   term_reg;
  logic [W-1:0]   value_reg;
  logic           running_reg;
  logic           done_reg;
  logic           expired_reg;

  logic [W-1:0]      preset_san;
  logic [W-1:0]      value_step;
  logic [DIGITS-1:0] carry;
  logic              zero_load;
  logic              step_term;

  assign carry[0] = 1'b1;

  // Per digit: clamp the preset digit and form the next digit of a one-step ripple.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      localparam logic [3:0] MAXD = (gi % 2 == 1) ? 4'(TENS_MOD - 1) : 4'd9;
      logic [3:0] p_d;
      logic [3:0] v_d;
      logic [3:0] s_d;
      logic       at_edge;

      assign p_d = preset[4*gi +: 4];
      assign preset_san[4*gi +: 4] = (p_d > MAXD) ? MAXD : p_d;

      assign v_d     = value_reg[4*gi +: 4];
      assign at_edge = mode_up_reg ? (v_d >= MAXD) : (v_d == 4'd0);

      always_comb begin
        s_d = v_d;
        if (carry[gi]) begin
          if (mode_up_reg) s_d = at_edge ? 4'd0 : v_d + 4'd1;
          else             s_d = at_edge ? MAXD : v_d - 4'd1;
        end
      end

      assign value_step[4*gi +: 4] = s_d;

      if (gi < DIGITS - 1) begin : g_carry
        assign carry[gi+1] = carry[gi] & at_edge;
      end
    end
  endgenerate

  assign zero_load = (preset_san == '0);
  assign step_term = mode_up_reg ? (value_step == term_reg) : (value_step == '0);

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_reg   <= IDLE;
      mode_up_reg <= 1'b0;
      term_reg    <= '0;
      value_reg   <= '0;
      running_reg <= 1'b0;
      done_reg    <= 1'b0;
      expired_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (stop) begin
            state_reg   <= IDLE;
            expired_reg <= 1'b0;
          end else if (start) begin
            mode_up_reg <= up;
            term_reg    <= preset_san;
            value_reg   <= up ? '0 : preset_san;
            // A zero-length load terminates on the load edge itself.
            if (zero_load) begin
              state_reg   <= DONE;
              done_reg    <= 1'b1;
              expired_reg <= 1'b1;
              running_reg <= 1'b0;
            end else begin
              state_reg   <= RUN;
              running_reg <= 1'b1;
              expired_reg <= 1'b0;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state_reg   <= PAUSE;
            running_reg <= 1'b0;
          end else if (tick) begin
            value_reg <= value_step;
            if (step_term) begin
              state_reg   <= DONE;
              running_reg <= 1'b0;
              done_reg    <= 1'b1;
              expired_reg <= 1'b1;
            end
          end
        end
        PAUSE: begin
          if (stop) begin
            state_reg <= IDLE;
          end else if (start) begin
            state_reg   <= RUN;
            running_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign value   = value_reg;
  assign running = running_reg;
  assign done    = done_reg;
  assign expired = expired_reg;

endmodule

// File: tb/tb_bcd_run_timer.sv
// Bench for bcd_run_timer: directed scenarios plus random stimulus, checked every
// cycle against an integer-count model of the timer.
module tb_bcd_run_timer;

  localparam int DIGITS   = 4;
  localparam int TENS_MOD = 6;
  localparam int W        = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         clear = 1'b0;
  logic         tick = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         up = 1'b0;
  logic [W-1:0] preset = '0;
  logic [W-1:0] value;
  logic         running;
  logic         done;
  logic         expired;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  bcd_run_timer #(.DIGITS(DIGITS), .TENS_MOD(TENS_MOD)) dut (
    .clk(clk), .clear(clear), .tick(tick), .start(start), .stop(stop), .up(up),
    .preset(preset), .value(value), .running(running), .done(done), .expired(expired)
  );

  always #5 clk = ~clk;

  function automatic int modof(int i);
    return (i % 2 == 1) ? TENS_MOD : 10;
  endfunction

  function automatic logic [W-1:0] to_bcd(int n);
    logic [W-1:0] r = '0;
    int m = n;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(m % modof(i));
      m = m / modof(i);
    end
    return r;
  endfunction

  function automatic int sanit(logic [W-1:0] p);
    int n = 0;
    int w = 1;
    for (int i = 0; i < DIGITS; i++) begin
      int d = int'(p[4*i +: 4]);
      if (d > modof(i) - 1) d = modof(i) - 1;
      n += d * w;
      w *= modof(i);
    end
    return n;
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: the count is a plain integer; states 0 idle, 1 run, 2 pause, 3 done.
  int m_st = 0;
  int m_count = 0;
  int m_term = 0;
  bit m_up = 1'b0;
  bit m_done = 1'b0;

  always @(posedge clk or negedge clear) begin
    if (!clear) begin
      m_st = 0; m_count = 0; m_term = 0; m_up = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (stop) begin
        if (m_st == 1) m_st = 2;
        else if (m_st == 2 || m_st == 3) m_st = 0;
      end else if (start && (m_st == 0 || m_st == 3)) begin
        m_up    = up;
        m_term  = sanit(preset);
        m_count = up ? 0 : m_term;
        if (m_term == 0) begin m_st = 3; m_done = 1'b1; end
        else m_st = 1;
      end else if (start && m_st == 2) begin
        m_st = 1;
      end else if (tick && m_st == 1) begin
        m_count += m_up ? 1 : -1;
        if (m_count == (m_up ? m_term : 0)) begin m_st = 3; m_done = 1'b1; end
      end
    end
  end

  always @(negedge clk) begin
    check("value",   32'(value),   32'(to_bcd(m_count)));
    check("running", 32'(running), 32'(m_st == 1));
    check("done",    32'(done),    32'(m_done));
    check("expired", 32'(expired), 32'(m_st == 3));
    if (done) done_cnt++;
  end

  task automatic cyc(input logic t, input logic s, input logic p);
    tick = t; start = s; stop = p;
    @(negedge clk);
    #1;
    tick = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic load(input logic [W-1:0] pr, input logic u);
    preset = pr; up = u;
    cyc(1'b0, 1'b1, 1'b0);
  endtask

  task automatic ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      for (int j = 1; j < gap; j++) cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int d3, d2, d1, d0;
    logic s_r, p_r;
    repeat (2) @(negedge clk);
    #1;
    check("rst_value", 32'(value), 32'h0);
    check("rst_flags", {29'd0, running, done, expired}, 32'h0);
    clear = 1'b1;
    cyc(0, 0, 0);

    // Down-count borrow chain.
    load(16'h0102, 1'b0);
    check("dn_load", 32'(value), 32'h0102);
    check("dn_run", 32'(running), 32'h1);
    repeat (3) cyc(0, 0, 0);
    ticks(1, 4); check("dn_1", 32'(value), 32'h0101);
    ticks(1, 4); check("dn_2", 32'(value), 32'h0100);
    ticks(1, 4); check("dn_3", 32'(value), 32'h0059);
    check("dn_nodone", done_cnt, 0);
    ticks(59, 4);
    check("dn_end", 32'(value), 32'h0000);
    check("dn_exp", {30'd0, running, expired}, 32'h1);
    check("dn_donecnt", done_cnt, 1);

    // Up-count to preset, started from DONE.
    load(16'h0010, 1'b1);
    check("up_load", 32'(value), 32'h0000);
    ticks(9, 1);
    check("up_9", 32'(value), 32'h0009);
    cyc(1, 0, 0);
    check("up_term", {value, 13'd0, running, done, expired}, {16'h0010, 16'h0003});
    ticks(3, 1);
    check("up_hold", {value, 15'd0, expired}, {16'h0010, 16'h0001});
    check("up_donecnt", done_cnt, 2);

    // Sanitise, pause/resume and priority.
    cyc(0, 0, 1);
    check("done_stop", 32'(expired), 32'h0);
    load(16'h0979, 1'b0);
    check("sanit", 32'(value), 32'h0959);
    cyc(1, 0, 1);
    check("tick_stop", {value, 15'd0, running}, {16'h0959, 16'h0000});
    ticks(3, 1);
    check("pause_hold", 32'(value), 32'h0959);
    cyc(0, 1, 0);
    check("resume", {value, 15'd0, running}, {16'h0959, 16'h0001});
    ticks(1, 1);
    check("resume_step", 32'(value), 32'h0958);
    cyc(0, 1, 1);
    check("startstop_run", 32'(running), 32'h0);
    cyc(0, 0, 1);
    ticks(2, 1);
    check("idle_hold", {value, 14'd0, running, expired}, {16'h0958, 16'h0000});

    // Zero-length load.
    load(16'h0000, 1'b0);
    check("zero_load", {value, 13'd0, running, done, expired}, {16'h0000, 16'h0003});
    cyc(0, 0, 0);
    check("zero_after", {29'd0, running, done, expired}, 32'h1);

    // Tick coincident with load start.
    cyc(0, 0, 1);
    preset = 16'h0123; up = 1'b0;
    cyc(1, 1, 0);
    check("tick_load", 32'(value), 32'h0123);

    // Asynchronous reset mid-run.
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    load(16'h0100, 1'b1);
    ticks(37, 1);
    check("pre_clr", 32'(value), 32'h0037);
    #1 clear = 1'b0;
    #1;
    check("async_clr", {value, 13'd0, running, done, expired}, 32'h0);
    #1 clear = 1'b1;
    @(negedge clk); #1;
    ticks(3, 1);
    check("clr_idle", {value, 15'd0, running}, 32'h0);

    // Random phase, checked by the per-cycle compare process.
    for (int c = 0; c < 20000; c++) begin
      d0 = $urandom_range(0, 9);
      d1 = $urandom_range(0, 9);
      d2 = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 9) : $urandom_range(0, 1);
      d3 = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 9) : 0;
      preset = {4'(d3), 4'(d2), 4'(d1), 4'(d0)};
      up = 1'($urandom_range(0, 1));
      p_r = ($urandom_range(0, 99) == 0);
      s_r = ($urandom_range(0, 7) == 0);
      if (m_st == 1 && !p_r) s_r = 1'b0;
      if ($urandom_range(0, 1999) == 0) begin
        clear = 1'b0;
        #1 clear = 1'b1;
      end
      cyc(1'($urandom_range(0, 1)), s_r, p_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
